tetron_placement_checker: RTL
=============================

Name: tetron_placement_checker

Overview:
Consumes the four block offsets produced by a tetron shaper plus the pivot position. Decides whether the resulting placement is legal against the playfield occupancy store. Walks the four blocks sequentially, issuing one playfield read per on-board block, and reports collide / out-of-bounds. Sits between the shaper outputs and the game-control FSM, which uses the verdict to accept or reject a move, rotation or drop.

Parameters:
BOARD_W, 10, playfield width in cells (columns 0..BOARD_W-1)
BOARD_H, 20, playfield height in cells (rows 0..BOARD_H-1, row 0 at top)
COORD_W, 5, width of pivot coordinates and block offsets

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
start  in  1  request check; sampled only in IDLE
pivot_row  in  COORD_W  pivot row, unsigned
pivot_col  in  COORD_W  pivot column, unsigned
blk1_voffset..blk4_voffset  in  COORD_W each  block row offsets, two's complement
blk1_hoffset..blk4_hoffset  in  COORD_W each  block column offsets, two's complement
pf_rd_en  out  1  playfield read strobe
pf_rd_row  out  COORD_W  read row
pf_rd_col  out  COORD_W  read column
pf_rd_data  in  1  occupancy of the cell addressed in the previous cycle (1 = filled)
busy  out  1  high from start acceptance until done
done  out  1  one-cycle pulse when the verdict is valid
collide  out  1  placement illegal (occupied cell or out of bounds)
oob  out  1  illegal because a block left the side or bottom walls

Behaviour:
- Reset (async, any state): state=IDLE; busy, done, collide, oob, pf_rd_en = 0; pf_rd_row/col = 0; block index = 0; latched inputs cleared. An in-flight check is discarded, and no done is issued for it.
- IDLE: start=1 at edge N latches pivot and all 8 offsets, clears collide/oob, sets index=0, and moves to CHECK. Inputs may change after edge N without effect.
- start while not IDLE is ignored and is not queued.
- Coordinates: row = zero-ext(pivot_row) + sign-ext(voffset); col likewise. Computed in COORD_W+2 signed bits, with no wrap.
- CHECK (block[index]):
  - col<0, col>=BOARD_W or row>=BOARD_H: collide=1, oob=1, go DONE.
  - row<0 (above the top, legal spawn area): no read. If index==3, go DONE; else index+1 and stay in CHECK.
  - Otherwise: pf_rd_en=1 this cycle, pf_rd_row/col = computed coords (low COORD_W bits), go WAIT.
- pf_rd_en/row/col are combinational from state and are 0 outside CHECK-with-read.
- WAIT: sample pf_rd_data. If 1: collide=1, oob=0, go DONE. Else, if index==3, go DONE; else index+1 and go CHECK.
- DONE: done=1 for exactly one cycle, then go IDLE.
- Checking stops at the first illegal block, so later blocks are neither read nor evaluated.
- busy=1 in CHECK/WAIT/DONE.
- collide/oob hold their value until the next accepted start.
- Latency with start sampled at edge N: all four blocks read and free gives done high in cycle N+9. Each skipped block saves 1 cycle. An early exit reaches DONE in the cycle after the detecting state.
- Blocks are evaluated in order 1,2,3,4. The playfield read port has a fixed one-cycle latency and no backpressure.

Decomposition:
- Shared tetris definitions package/include: BOARD_W, BOARD_H, COORD_W, the state encoding (IDLE, CHECK, WAIT, DONE). The shaper, this block and the game FSM share these.
- Sub-module tetron_cell_locator (combinational): pivot + offset → row, col, above_top, out_of_bounds. Instantiated once and fed by an index mux.

Test Plan:
- Horizontal I, offsets (v,h) = (0,0),(0,-1),(0,1),(0,2), pivot (5,4), empty field, start at edge N → reads (5,4),(5,3),(5,5),(5,6) in cycles N+1,3,5,7; done at N+9; collide=0, oob=0.
- Same shape, pivot (5,8) → block4 col 10: reads for blocks 1-3 only; done at N+8; collide=1, oob=1.
- Same shape, pivot (5,4), cell (5,3) filled → WAIT at N+4 sees 1; done at N+5; collide=1, oob=0; no read of (5,5).
- Vertical I, offsets (0,0),(-1,0),(1,0),(2,0), pivot (0,3), empty field → block2 row -1 skipped with no pf_rd_en; done at N+8; collide=0. Pivot (18,3) → block4 row 20: oob=1.
- Start pulsed again during busy → ignored, single done. rst asserted in WAIT → all outputs 0 immediately, no done. A following start gives a normal result.
- Back-to-back: new start in the cycle after done → accepted. collide/oob clear at acceptance and reflect only the new check.

Source files
------------

// File: rtl/tetron_placement_checker_pkg.sv
// Tetris definitions shared by the shaper, the placement checker and the game FSM:
// board geometry, coordinate width and the checker state encoding.
package tetron_placement_checker_pkg;
  localparam int BOARD_W  = 10;
  localparam int BOARD_H  = 20;
  localparam int COORD_W  = 5;
  localparam int NUM_BLKS = 4;

  typedef enum logic [1:0] {IDLE, CHECK, WAIT, DONE} chk_state_e;
endpackage

// File: rtl/tetron_placement_checker_if.sv
// Checker bus: the request from the shaper/game FSM, the verdict and the playfield read port.
interface tetron_placement_checker_if #(parameter int COORD_W = 5);
  logic               start;
  logic [COORD_W-1:0] pivot_row, pivot_col;
  logic [COORD_W-1:0] blk1_voffset, blk2_voffset, blk3_voffset, blk4_voffset;
  logic [COORD_W-1:0] blk1_hoffset, blk2_hoffset, blk3_hoffset, blk4_hoffset;
  logic               pf_rd_en;
  logic [COORD_W-1:0] pf_rd_row, pf_rd_col;
  logic               pf_rd_data;
  logic               busy, done, collide, oob;

  modport slave (
    input  start, pivot_row, pivot_col,
           blk1_voffset, blk2_voffset, blk3_voffset, blk4_voffset,
           blk1_hoffset, blk2_hoffset, blk3_hoffset, blk4_hoffset, pf_rd_data,
    output pf_rd_en, pf_rd_row, pf_rd_col, busy, done, collide, oob
  );

  modport master (
    output start, pivot_row, pivot_col,
           blk1_voffset, blk2_voffset, blk3_voffset, blk4_voffset,
           blk1_hoffset, blk2_hoffset, blk3_hoffset, blk4_hoffset, pf_rd_data,
    input  pf_rd_en, pf_rd_row, pf_rd_col, busy, done, collide, oob
  );
endinterface

// File: rtl/tetron_cell_locator.sv
// Pivot + signed offset -> board cell, with above-top and wall/floor classification.
module tetron_cell_locator #(
  parameter int BOARD_W = 10,
  parameter int BOARD_H = 20,
  parameter int COORD_W = 5
) (
  input  logic [COORD_W-1:0] pivot_row,
  input  logic [COORD_W-1:0] pivot_col,
  input  logic [COORD_W-1:0] voffset,
  input  logic [COORD_W-1:0] hoffset,
  output logic [COORD_W-1:0] row,
  output logic [COORD_W-1:0] col,
  output logic               above_top,
  output logic               out_of_bounds
);
  localparam logic signed [COORD_W+1:0] W_LIM = (COORD_W+2)'(BOARD_W);
  localparam logic signed [COORD_W+1:0] H_LIM = (COORD_W+2)'(BOARD_H);

  // Two extra bits so pivot + offset can neither wrap nor alias a negative result.
  logic signed [COORD_W+1:0] row_s, col_s;

  assign row_s = $signed({2'b00, pivot_row}) + $signed({{2{voffset[COORD_W-1]}}, voffset});
  assign col_s = $signed({2'b00, pivot_col}) + $signed({{2{hoffset[COORD_W-1]}}, hoffset});

  assign row           = row_s[COORD_W-1:0];
  assign col           = col_s[COORD_W-1:0];
  assign above_top     = row_s[COORD_W+1];
  assign out_of_bounds = col_s[COORD_W+1] || (col_s >= W_LIM) || (row_s >= H_LIM);
endmodule

// File: rtl/tetron_placement_checker.sv
// Walks the four tetron blocks in order, reading the playfield for each on-board
// block, and stops at the first block that hits a wall, the floor or a filled cell.
module tetron_placement_checker
  import tetron_placement_checker_pkg::*;
#(
  parameter int BOARD_W = tetron_placement_checker_pkg::BOARD_W,
  parameter int BOARD_H = tetron_placement_checker_pkg::BOARD_H,
  parameter int COORD_W = tetron_placement_checker_pkg::COORD_W
) (
  input logic                         clk,
  input logic                         rst,
  tetron_placement_checker_if.slave   bus
);
  chk_state_e                         state;
  logic [1:0]                         idx;
  logic [COORD_W-1:0]                 prow_q, pcol_q;
  logic [NUM_BLKS-1:0][COORD_W-1:0]   voff_q, hoff_q;
  logic                               busy_q, done_q, collide_q, oob_q;

  logic [COORD_W-1:0] cell_row, cell_col;
  logic               above_top, out_of_bounds, rd_en, last_blk;

  tetron_cell_locator #(.BOARD_W(BOARD_W), .BOARD_H(BOARD_H), .COORD_W(COORD_W)) u_loc (
    .pivot_row     (prow_q),
    .pivot_col     (pcol_q),
    .voffset       (voff_q[idx]),
    .hoffset       (hoff_q[idx]),
    .row           (cell_row),
    .col           (cell_col),
    .above_top     (above_top),
    .out_of_bounds (out_of_bounds)
  );

  assign last_blk      = (idx == 2'(NUM_BLKS-1));
  assign rd_en         = (state == CHECK) && !out_of_bounds && !above_top;
  assign bus.pf_rd_en  = rd_en;
  assign bus.pf_rd_row = rd_en ? cell_row : '0;
  assign bus.pf_rd_col = rd_en ? cell_col : '0;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.collide   = collide_q;
  assign bus.oob       = oob_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      prow_q    <= '0;
      pcol_q    <= '0;
      voff_q    <= '0;
      hoff_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      collide_q <= 1'b0;
      oob_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          prow_q    <= bus.pivot_row;
          pcol_q    <= bus.pivot_col;
          voff_q    <= {bus.blk4_voffset, bus.blk3_voffset, bus.blk2_voffset, bus.blk1_voffset};
          hoff_q    <= {bus.blk4_hoffset, bus.blk3_hoffset, bus.blk2_hoffset, bus.blk1_hoffset};
          idx       <= '0;
          collide_q <= 1'b0;
          oob_q     <= 1'b0;
          busy_q    <= 1'b1;
          state     <= CHECK;
        end
        CHECK: begin
          if (out_of_bounds) begin
            collide_q <= 1'b1;
            oob_q     <= 1'b1;
            done_q    <= 1'b1;
            state     <= DONE;
          end else if (above_top) begin
            // Spawn area above the board is always legal and needs no read.
            if (last_blk) begin
              done_q <= 1'b1;
              state  <= DONE;
            end else begin
              idx <= idx + 2'd1;
            end
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (bus.pf_rd_data) begin
            collide_q <= 1'b1;
            oob_q     <= 1'b0;
            done_q    <= 1'b1;
            state     <= DONE;
          end else if (last_blk) begin
            done_q <= 1'b1;
            state  <= DONE;
          end else begin
            idx   <= idx + 2'd1;
            state <= CHECK;
          end
        end
        DONE: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
